// File: rtl/serial_adder_n.sv
// Bit-serial N-bit add/subtract: one full-adder cell and a carry FF, LSB first.
// Latency: done pulses N+1 edges after start is accepted; one op per N+1 cycles.
// Backpressure: start is ignored while busy; the result holds until the next accepted start.
module serial_adder_n #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_bit;
  logic             a_bit;
  logic             b_bit;
  logic             s_bit;
  logic             carry_nxt;
  logic [N:0]       sum_shift;

  // Operands shift right each RUN cycle, so bit 0 is always the bit in flight.
  assign a_bit     = a_q[0];
  assign b_bit     = b_q[0];
  assign s_bit     = a_bit ^ b_bit ^ carry_q;
  assign carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
  assign last_bit  = (cnt_q == CNT_W'(N - 1));
  assign sum_shift = {s_bit, sum};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Accepting here gives back-to-back operation with no idle bubble.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B once here and seed the carry.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_nxt;
      cnt_q   <= cnt_q + CNT_W'(1);
      sum     <= sum_shift[N:1];
      if (last_bit) begin
        // The MSB operand bits are in flight now, so overflow needs no extra storage.
        cout <= carry_nxt;
        ovf  <= (a_bit == b_bit) && (s_bit != a_bit);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomized checks of serial_adder_n (N=4 and N=1) against an integer model.
module tb_serial_adder_n;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         sub1 = 1'b0;
  logic         cin1 = 1'b0;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         cout1;
  logic         ovf1;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder_n #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .sub(sub1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned wide sum for result/carry, signed range test for overflow.
  task automatic model(input int w, input int ua, input int ub, input logic ts, input logic tc,
                       output int es, output int ec, output int eo);
    int full, sa, sb, sr, half, span;
    span = 1 << w;
    half = 1 << (w - 1);
    sa = (ua >= half) ? ua - span : ua;
    sb = (ub >= half) ? ub - span : ub;
    if (ts) begin
      full = ua - ub + span;
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(tc);
      sr   = sa + sb + int'(tc);
    end
    es = full % span;
    ec = (full >= span) ? 1 : 0;
    eo = (sr < -half || sr > half - 1) ? 1 : 0;
  endtask

  // One operation on the N=4 unit; glitch>=0 pulses start and scrambles inputs in that RUN cycle.
  task automatic do_op(input int ta, input int tbv, input logic ts, input logic tc,
                       input int glitch, input string tag);
    int es, ec, eo, dc0;
    model(N, ta, tbv, ts, tc, es, ec, eo);
    @(negedge clk);
    a = N'(ta); b = N'(tbv); sub = ts; cin = tc; start = 1'b1;
    dc0 = done_cnt;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = (k == glitch);
      if (k == glitch) begin
        a = '1; b = '1; sub = ~ts; cin = ~tc;
      end
      chk({tag, " busy/done in RUN"}, {30'b0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk({tag, " busy/done at done"}, {30'b0, busy, done}, 32'd1);
    chk({tag, " sum"}, 32'(sum), es);
    chk({tag, " cout"}, 32'(cout), ec);
    chk({tag, " ovf"}, 32'(ovf), eo);
    @(negedge clk);
    chk({tag, " single done pulse"}, done_cnt - dc0, 32'd1);
    chk({tag, " sum held in IDLE"}, 32'(sum), es);
  endtask

  initial begin
    int es, ec, eo, dc0, cyc;
    logic [3:0] combo;

    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy/done", {30'b0, busy, done}, 32'd0);
    chk("reset sum/cout/ovf", {26'b0, sum, cout, ovf}, 32'd0);
    @(negedge clk);
    chk("idle after reset", {30'b0, busy, done}, 32'd0);

    // Directed additions and subtractions
    do_op(3, 5, 1'b0, 1'b0, -1, "add 3+5");
    do_op(15, 1, 1'b0, 1'b0, -1, "add 15+1");
    do_op(9, 6, 1'b0, 1'b1, -1, "add 9+6+1");
    do_op(5, 7, 1'b1, 1'b1, -1, "sub 5-7");
    do_op(8, 1, 1'b1, 1'b0, -1, "sub 8-1");
    do_op(2, 3, 1'b0, 1'b0, 1, "start ignored in RUN");

    // Reset in the middle of an operation
    @(negedge clk);
    a = 4'd7; b = 4'd7; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    chk("mid-op reset busy/done", {30'b0, busy, done}, 32'd0);
    chk("mid-op reset sum/cout/ovf", {26'b0, sum, cout, ovf}, 32'd0);
    repeat (N + 2) @(negedge clk);
    chk("no done after reset", done_cnt - dc0, 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    a = 4'd1; b = 4'd1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int op = 0; op < 2; op++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 20);
      chk($sformatf("b2b op%0d cycles to done", op), cyc, N + 1);
      model(N, (op == 0) ? 1 : 6, (op == 0) ? 1 : 6, 1'b0, 1'b0, es, ec, eo);
      chk($sformatf("b2b op%0d sum", op), 32'(sum), es);
      chk($sformatf("b2b op%0d ovf", op), 32'(ovf), eo);
      if (op == 0) begin
        a = 4'd6; b = 4'd6;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b idle after release", {30'b0, busy, done}, 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 3)) - 1, $sformatf("rand%0d", i));
    end

    // N=1 instance, all input combinations
    for (int c = 0; c < 16; c++) begin
      combo = 4'(c);
      model(1, int'(combo[3]), int'(combo[2]), combo[1], combo[0], es, ec, eo);
      @(negedge clk);
      a1 = combo[3]; b1 = combo[2]; sub1 = combo[1]; cin1 = combo[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("n1 c%0d busy/done in RUN", c), {30'b0, busy1, done1}, 32'd2);
      @(negedge clk);
      chk($sformatf("n1 c%0d busy/done at done", c), {30'b0, busy1, done1}, 32'd1);
      chk($sformatf("n1 c%0d sum/cout/ovf", c), {29'b0, sum1, cout1, ovf1},
          32'((es << 2) | (ec << 1) | eo));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised N-bit bit-serial adder/subtractor. Generalises the team's combinational 3-bit+1-bit adder lab circuit.
- Reuses a single full-adder cell plus a carry flip-flop and processes one bit per clock, LSB first.
- Uses a start/busy/done handshake and holds the result until the next operation.
- Sits as a compute unit under a lab controller or testbench driver.

Parameters:
N, 4, operand/result width in bits (legal N >= 1)

Ports:
clk    input   1   rising-edge clock
reset  input   1   synchronous, active-high reset
start  input   1   request; sampled only in IDLE or DONE
a      input   N   operand A, captured on accepted start
b      input   N   operand B, captured on accepted start
sub    input   1   0 = A+B+cin, 1 = A-B (A + ~B + 1); captured on accepted start
cin    input   1   carry-in for add mode; ignored when sub=1; captured on accepted start
busy   output  1   high while bits are being processed (RUN)
done   output  1   one-cycle pulse when result becomes valid
sum    output  N   result, valid from done cycle until next accepted start
cout   output  1   carry out of MSB (in sub mode: 1 = no borrow)
ovf    output  1   signed two's-complement overflow

Behaviour:
- Clock and reset:
  - Single clock domain; one clock, rising edge.
  - Reset is synchronous and active-high. At any edge with reset=1: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry FF=0.
  - Reset has priority over start and over RUN. Reset mid-operation abandons the operation and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0; sum/cout/ovf hold their last values.
  - start=1 at edge E0 -> capture a, b (b inverted if sub), sub, and carry FF = (sub ? 1 : cin); clear counter; go to RUN.
- RUN:
  - busy=1, done=0.
  - At each edge, bit i = counter: s = a[i]^b'[i]^c; carry FF <= majority(a[i], b'[i], c); s shifts into sum from the MSB side (shift-right result register); counter increments.
  - start is ignored while busy; captured operands are not disturbed by input changes.
  - After the edge that processes bit N-1 (edge E0+N), go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - sum holds the full result; cout = final carry; ovf = (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]), evaluated on captured operands.
  - Next edge: start=1 -> back-to-back accept, same actions as from IDLE, go to RUN (no idle bubble). Otherwise go to IDLE.
- Latency:
  - done is high during the cycle following edge E0+N, i.e. N+1 edges after start is sampled.
  - Throughput is one operation per N+1 cycles.
- Result hold: sum/cout/ovf are stable from done until the edge that accepts the next start. During RUN they are undefined to observers and must not be used.
- N=1: RUN lasts one cycle; ovf rule still applies.
- Counter width: $clog2(N)+1 bits; no wrap-around occurs within an operation.

Test Plan:
1. N=4, reset 2 cycles, then a=3, b=5, sub=0, cin=0, start 1 cycle -> busy high 4 cycles, done 5 edges after start; sum=8, cout=0, ovf=1.
2. a=15, b=1, sub=0, cin=0 -> sum=0, cout=1, ovf=0. Then a=9, b=6, cin=1 -> sum=0, cout=1, ovf=0.
3. a=5, b=7, sub=1, cin=1 (must be ignored) -> sum=14 (-2), cout=0, ovf=0. Then a=8, b=1, sub=1 -> sum=7, cout=1, ovf=1.
4. Start a=2, b=3. In RUN, pulse start and change a=15, b=15 -> result unaffected: sum=5, exactly one done pulse.
5. Start a=7, b=7. Assert reset at second RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows.
6. Hold start=1 continuously with operands changing on each done cycle: (1,1) then (6,6) -> done every 5 cycles, no idle cycle between; sum=2 then 12, ovf=0 then 1.
